// File: rtl/pwm_dac_sequencer_if.sv
// ============================================================================
// pwm_dac_sequencer_if : control, LUT and PWM-side signals of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface pwm_dac_sequencer_if #(
  parameter int DIV_W  = 20,
  parameter int ADDR_W = 8,
  parameter int DUTY_W = 8
);
  logic              enable;
  logic              cfg_load;
  logic [DIV_W-1:0]  div_cfg;
  logic [ADDR_W-1:0] step_cfg;
  logic [DUTY_W-1:0] amp_cfg;
  logic              pwm_wrap;
  logic [DUTY_W-1:0] lut_data;
  logic [ADDR_W-1:0] lut_addr;
  logic [DUTY_W-1:0] duty;
  logic              sample_tick;
  logic              busy;
  logic              overrun;

  modport master (
    output enable, cfg_load, div_cfg, step_cfg, amp_cfg, pwm_wrap, lut_data,
    input  lut_addr, duty, sample_tick, busy, overrun
  );

  modport slave (
    input  enable, cfg_load, div_cfg, step_cfg, amp_cfg, pwm_wrap, lut_data,
    output lut_addr, duty, sample_tick, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/pwm_dac_sequencer.sv
// ============================================================================
// pwm_dac_sequencer : paces LUT reads, scales samples, commits duty at PWM wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_dac_sequencer #(
  parameter int               DIV_W   = 20,
  parameter logic [DIV_W-1:0] DEF_DIV = 20'd531999,
  parameter int               ADDR_W  = 8,
  parameter int               DUTY_W  = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  pwm_dac_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam int               c_PW      = 2 * DUTY_W + 2;
  localparam logic [DUTY_W:0]  c_MID     = {2'b01, {(DUTY_W-1){1'b0}}};
  localparam logic [DIV_W-1:0] c_MIN_DIV = DIV_W'(3);

  logic [2:0]        r_state;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [ADDR_W-1:0] r_step;
  logic [DUTY_W-1:0] r_amp;
  logic [ADDR_W-1:0] r_phase;
  logic [ADDR_W-1:0] r_lut_addr;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_staged;
  logic              r_overrun;

  logic                    w_idle;
  logic                    w_tick;
  logic                    w_accept;
  logic [ADDR_W-1:0]       w_next_phase;
  logic signed [DUTY_W:0]  w_diff;
  logic signed [c_PW-1:0]  w_prod;
  logic [DUTY_W-1:0]       w_staged;

  assign w_idle       = (r_state == S_IDLE);
  assign w_tick       = (r_cnt == r_div) && !w_idle;
  // A coincident cfg_load swallows the tick entirely.
  assign w_accept     = w_tick && !bus.cfg_load;
  assign w_next_phase = r_phase + r_step;

  // Offset-binary to signed, scale, shift back; the result never leaves 0..254.
  assign w_diff   = $signed({1'b0, bus.lut_data} - c_MID);
  assign w_prod   = c_PW'(w_diff) * c_PW'($signed({1'b0, r_amp}));
  assign w_staged = DUTY_W'(w_prod >>> DUTY_W) + c_MID[DUTY_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= DEF_DIV;
      r_step <= ADDR_W'(1);
      r_amp  <= '1;
    end else if (bus.cfg_load) begin
      r_div  <= (bus.div_cfg < c_MIN_DIV) ? c_MIN_DIV : bus.div_cfg;
      r_step <= bus.step_cfg;
      r_amp  <= bus.amp_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.cfg_load || w_idle) begin
      r_cnt <= '0;
    end else if (r_cnt == r_div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_lut_addr <= '0;
      r_duty     <= c_MID[DUTY_W-1:0];
      r_staged   <= c_MID[DUTY_W-1:0];
      r_overrun  <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        r_overrun <= 1'b0;
      end
      if (!bus.enable) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WAIT;
          S_WAIT: begin
            if (w_accept) begin
              r_phase    <= w_next_phase;
              r_lut_addr <= w_next_phase;
              r_state    <= S_READ;
            end
          end
          S_READ: begin
            r_state <= S_SCALE;
            if (w_accept) begin
              r_overrun <= 1'b1;
            end
          end
          S_SCALE: begin
            r_staged <= w_staged;
            r_state  <= S_HOLD;
            if (w_accept) begin
              r_overrun <= 1'b1;
            end
          end
          S_HOLD: begin
            if (bus.pwm_wrap) begin
              r_duty <= r_staged;
              if (w_accept) begin
                r_phase    <= w_next_phase;
                r_lut_addr <= w_next_phase;
                r_state    <= S_READ;
              end else begin
                r_state <= S_WAIT;
              end
            end else if (w_accept) begin
              r_overrun <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.lut_addr    = r_lut_addr;
  assign bus.duty        = r_duty;
  assign bus.sample_tick = w_tick;
  assign bus.busy        = (r_state == S_READ) || (r_state == S_SCALE) || (r_state == S_HOLD);
  assign bus.overrun     = r_overrun;

endmodule

`default_nettype wire

// File: doc/pwm_dac_sequencer.md
# pwm_dac_sequencer

Sample scheduler and amplitude controller for the PWM DAC datapath. It runs on the single oscillator clock and paces the sine-table lookups with a clock-enable divider instead of a derived clock. It advances the phase-accumulated table address, scales each table sample by a programmable amplitude, and commits the result to the PWM generator's duty input only at a PWM period boundary, so the duty never changes mid-period. It sits between the sine LUT (registered read, 1-cycle latency) and the PWM generator.

## Interface

- DIV_W, 20: divider width.
- DEF_DIV, 20'd531999: reset sample period minus 1, giving 100 Hz at 53.20 MHz.
- ADDR_W, 8: LUT address and phase width.
- DUTY_W, 8: sample, amplitude and duty width.

- clk  in  1  oscillator clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run when 1; IDLE when 0.
- cfg_load  in  1  1-cycle strobe that latches div_cfg, step_cfg and amp_cfg.
- div_cfg  in  DIV_W  sample period minus 1, in clk cycles.
- step_cfg  in  ADDR_W  phase increment per sample.
- amp_cfg  in  DUTY_W  amplitude scale; 255 is approximately unity.
- pwm_wrap  in  1  pulse from the PWM generator at counter wrap.
- lut_data  in  DUTY_W  offset-binary sample from the registered LUT.
- lut_addr  out  ADDR_W  registered LUT address.
- duty  out  DUTY_W  registered duty to the PWM generator.
- sample_tick  out  1  high in the cycle the divider reaches its terminal count.
- busy  out  1  high in READ, SCALE and HOLD.
- overrun  out  1  sticky flag: a sample tick was dropped.

## Operation

- **Shadow registers (div, step, amp):**
  - Reset values: DEF_DIV, 1, 255.
  - cfg_load latches all three in any state.
  - A div_cfg value below 3 is latched as 3.
  - cfg_load also clears the divider counter and overrun. Phase is unchanged.
- **Divider:**
  - Counts 0..div while the FSM is not in IDLE; held at 0 in IDLE.
  - sample_tick = (cnt == div) && !IDLE. The counter returns to 0 on the following edge.
  - Tick period is div+1 cycles.
- **FSM states: IDLE, WAIT, READ, SCALE, HOLD.**
  - IDLE → WAIT when enable = 1.
  - WAIT + tick: phase ← phase + step (mod 2^ADDR_W), lut_addr ← new phase, → READ.
  - READ → SCALE. The LUT samples lut_addr during this cycle.
  - SCALE: staged ← 128 + ((signed(lut_data − 128) × amp) >>> 8), → HOLD.
    - Widths: a 9-bit signed value times a 9-bit zero-extended value gives a 17-bit signed product.
    - Result range is 0..254, so no saturation is needed.
  - HOLD + pwm_wrap: duty ← staged, → WAIT.
  - HOLD + pwm_wrap + tick in the same cycle: commit duty, accept the tick (advance phase and lut_addr), → READ.
- **Overrun:** a tick in READ, SCALE, or HOLD without pwm_wrap sets overrun. The tick is dropped and phase is not advanced. overrun clears only on rst or cfg_load.
- **pwm_wrap outside HOLD:** ignored and not latched.
- **enable = 0 in any state:** → IDLE on the next edge. The staged sample is discarded; duty, phase and lut_addr hold.
- **cfg_load in the same cycle as a tick:** cfg_load wins and the tick is suppressed (no phase advance, no overrun).
- **rst in any state:** all registers go to their reset values on the next edge. rst has priority over cfg_load and enable.

## Timing

- Reset values:
  - duty = 128, lut_addr = 0, phase = 0, cnt = 0, state = IDLE.
  - sample_tick = 0, busy = 0, overrun = 0.
- For a tick in cycle T (state WAIT):
  - lut_addr is valid at T+1.
  - lut_data is valid at T+2.
  - staged is valid at T+3 (HOLD).
  - If pwm_wrap arrives in cycle W ≥ T+3, duty is visible at W+1.
- Minimum tick-to-duty latency is 4 cycles.
- With div = 3 and pwm_wrap held at 1, there are no overruns.
- busy is high in cycles T+1 through the commit cycle W.

## Test plan

- **Reset:** assert rst for 2 cycles mid-HOLD → duty = 128, lut_addr = 0, busy = 0, overrun = 0, sample_tick = 0.
- **Nominal sequencing:** cfg_load with div_cfg = 9, step = 1, amp = 255; enable; pwm_wrap held at 1; LUT model where data = addr → sample_tick every 10 cycles, lut_addr = 1, 2, 3…, duty is updated 4 cycles after each tick.
- **Scaling:**
  - amp = 255: lut_data 255 → duty 254; lut_data 0 → duty 0.
  - amp = 128: lut_data 255 → duty 191.
  - amp = 0: any lut_data → duty 128.
- **Wrap and clamp:**
  - step = 0x40 from phase 0xC0 → lut_addr 0x00.
  - div_cfg = 1 → latched as 3, tick every 4 cycles.
- **Overrun:** div_cfg = 3, pwm_wrap held at 0 → the second tick sets overrun = 1, lut_addr is unchanged, duty holds. A later cfg_load → overrun = 0.
- **Boundary events:**
  - pwm_wrap and tick in the same HOLD cycle → duty commits and lut_addr advances on the same edge.
  - cfg_load coincident with a tick → no advance.
  - enable dropped in HOLD → IDLE next cycle, busy = 0, duty unchanged.
